// File: rtl/tri_bus_arbiter.sv
// Output-enable sequencer for a shared tri-state bus: round-robin grant,
// at most one enable at a time, and a fixed all-off gap on every owner change.
module tri_bus_arbiter #(
  parameter  int M    = 4,
  parameter  int HOLD = 4,
  parameter  int TURN = 1,
  localparam int IW   = $clog2(M),
  localparam int HW   = $clog2(HOLD + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [M-1:0]  req,
  output logic [M-1:0]  enable,
  output logic [IW-1:0] grant_id,
  output logic          bus_valid,
  output logic [1:0]    dbg_state
);

  // Handshake: req[k] is a level request sampled on every rising edge; the
  // bus is owned by k exactly while enable[k] is high (no ready/ack path).

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        r_state;
  logic [M-1:0]  r_enable;
  logic [IW-1:0] r_grant_id;
  logic          r_bus_valid;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic [2:0]    r_gap_cnt;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_idx;
  int            w_sum;
  logic [M-1:0]  w_pick_mask;
  logic [M-1:0]  w_owner_mask;
  logic          w_others;
  logic          w_release;
  logic [IW-1:0] w_next_ptr;

  // Search upward from the pointer with wrap; walking downward lets the
  // nearest set bit overwrite any farther candidate.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = 0;
    w_idx   = '0;
    for (int i = M - 1; i >= 0; i--) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= M) w_sum = w_sum - M;
      w_idx = IW'(w_sum);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_pick_mask  = M'(1) << w_pick;
  assign w_owner_mask = M'(1) << r_grant_id;
  assign w_others     = |(req & ~w_owner_mask);
  assign w_release    = !req[r_grant_id] || ((r_hold_cnt == HW'(HOLD)) && w_others);
  assign w_next_ptr   = (r_grant_id == IW'(M - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= ST_IDLE;
      r_enable    <= '0;
      r_grant_id  <= '0;
      r_bus_valid <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state     <= ST_GRANT;
            r_enable    <= w_pick_mask;
            r_grant_id  <= w_pick;
            r_bus_valid <= 1'b1;
            r_hold_cnt  <= HW'(1);
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            // Pointer moves past the old owner so it ranks last next time.
            r_state     <= ST_GAP;
            r_enable    <= '0;
            r_bus_valid <= 1'b0;
            r_ptr       <= w_next_ptr;
            r_gap_cnt   <= 3'd1;
          end else if (r_hold_cnt != HW'(HOLD)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 3'(TURN)) begin
            if (w_found) begin
              r_state     <= ST_GRANT;
              r_enable    <= w_pick_mask;
              r_grant_id  <= w_pick;
              r_bus_valid <= 1'b1;
              r_hold_cnt  <= HW'(1);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 3'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_enable    <= '0;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign enable    = r_enable;
  assign grant_id  = r_grant_id;
  assign bus_valid = r_bus_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: one instance with TURN=1, one with TURN=3.
module tb_tri_bus_arbiter;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic       clk;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] enable;
  logic [1:0] grant_id;
  logic       bus_valid;
  logic [1:0] dbg_state;

  logic [3:0] req3;
  logic [3:0] enable3;
  logic [1:0] grant_id3;
  logic       bus_valid3;
  logic [1:0] dbg_state3;

  int n_cmp;
  int n_err;

  logic [3:0] prev_en;
  logic [3:0] prev_en3;

  tri_bus_arbiter #(.M(4), .HOLD(4), .TURN(1)) u_dut (
    .clk       (clk),
    .rstN      (rstN),
    .req       (req),
    .enable    (enable),
    .grant_id  (grant_id),
    .bus_valid (bus_valid),
    .dbg_state (dbg_state)
  );

  tri_bus_arbiter #(.M(4), .HOLD(4), .TURN(3)) u_dut_t3 (
    .clk       (clk),
    .rstN      (rstN),
    .req       (req3),
    .enable    (enable3),
    .grant_id  (grant_id3),
    .bus_valid (bus_valid3),
    .dbg_state (dbg_state3)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #1;
    rstN = 1'b1;
  endtask

  // Continuous one-hot / no-overlap / bus_valid watch on both instances
  initial begin
    prev_en  = '0;
    prev_en3 = '0;
  end

  always @(negedge clk) begin
    if (rstN) begin
      check("onehot", 32'($countones(enable) <= 1), 32'd1);
      check("overlap", 32'((prev_en != 0) && (enable != 0) && (prev_en != enable)), 32'd0);
      check("bus_valid_or", 32'(bus_valid), 32'(|enable));
      check("onehot_t3", 32'($countones(enable3) <= 1), 32'd1);
      check("overlap_t3", 32'((prev_en3 != 0) && (enable3 != 0) && (prev_en3 != enable3)), 32'd0);
      check("bus_valid_or_t3", 32'(bus_valid3), 32'(|enable3));
    end
    prev_en  = enable;
    prev_en3 = enable3;
  end

  logic [3:0] exp_en;
  int owner;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstN  = 1'b0;
    req   = '0;
    req3  = '0;

    // Reset state, before any clock edge
    #1;
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_bus_valid", 32'(bus_valid), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick(2);
    rstN = 1'b1;

    // Reset mid-grant
    req = 4'b0100;
    tick(1);
    check("t1_grant_en", 32'(enable), 32'h4);
    check("t1_grant_id", 32'(grant_id), 32'h2);
    tick(1);
    #1;
    rstN = 1'b0;
    #1;
    check("t1_async_en", 32'(enable), 32'h0);
    check("t1_async_bv", 32'(bus_valid), 32'h0);
    check("t1_async_id", 32'(grant_id), 32'h0);
    check("t1_async_st", 32'(dbg_state), 32'(ST_IDLE));
    req  = 4'b0001;
    rstN = 1'b1;
    tick(1);
    check("t1_after_en", 32'(enable), 32'h1);
    check("t1_after_id", 32'(grant_id), 32'h0);
    req = 4'b0000;
    tick(1);
    check("t1_rel_en", 32'(enable), 32'h0);
    check("t1_rel_st", 32'(dbg_state), 32'(ST_GAP));
    tick(1);
    check("t1_idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // Lone requester keeps the bus past HOLD
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t2_lone_en", 32'(enable), 32'h4);
    end
    req = 4'b0000;
    tick(1);
    check("t2_drop_en", 32'(enable), 32'h0);
    check("t2_drop_bv", 32'(bus_valid), 32'h0);
    check("t2_drop_id", 32'(grant_id), 32'h2);
    tick(1);
    check("t2_idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // Full contention: 4 granted + 1 gap per owner, period 20
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 24; t++) begin
      tick(1);
      owner  = (t / 5) % 4;
      exp_en = ((t % 5) < 4) ? (4'b0001 << owner) : 4'b0000;
      check("t3_rr_en", 32'(enable), 32'(exp_en));
      check("t3_rr_id", 32'(grant_id), 32'(owner));
    end

    // Early release hands over after one gap cycle
    do_reset();
    req = 4'b0101;
    tick(1);
    check("t4_own0_a", 32'(enable), 32'h1);
    tick(1);
    check("t4_own0_b", 32'(enable), 32'h1);
    req = 4'b0100;
    tick(1);
    check("t4_gap_en", 32'(enable), 32'h0);
    tick(1);
    check("t4_new_en", 32'(enable), 32'h4);
    check("t4_new_id", 32'(grant_id), 32'h2);

    // Pointer wrap from owner 3 to owner 0, then back to 3
    do_reset();
    req = 4'b1000;
    tick(1);
    check("t5_own3", 32'(enable), 32'h8);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t5_own3_hold", 32'(enable), 32'h8);
    end
    tick(1);
    check("t5_gap1", 32'(enable), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t5_own0", 32'(enable), 32'h1);
    end
    tick(1);
    check("t5_gap2", 32'(enable), 32'h0);
    tick(1);
    check("t5_back3", 32'(enable), 32'h8);
    check("t5_back3_id", 32'(grant_id), 32'h3);
    req = 4'b0000;

    // Late request in the last gap cycle with TURN=3
    do_reset();
    req3 = 4'b0001;
    tick(1);
    check("t6_own0", 32'(enable3), 32'h1);
    req3 = 4'b0000;
    tick(1);
    check("t6_gap1_en", 32'(enable3), 32'h0);
    check("t6_gap1_st", 32'(dbg_state3), 32'(ST_GAP));
    tick(1);
    check("t6_gap2_en", 32'(enable3), 32'h0);
    tick(1);
    check("t6_gap3_en", 32'(enable3), 32'h0);
    check("t6_gap3_st", 32'(dbg_state3), 32'(ST_GAP));
    req3 = 4'b0010;
    tick(1);
    check("t6_late_en", 32'(enable3), 32'h2);
    check("t6_late_id", 32'(grant_id3), 32'h1);
    check("t6_late_st", 32'(dbg_state3), 32'(ST_GRANT));
    req3 = 4'b0000;
    tick(2);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Output-enable sequencer for a shared N-bit tri-state result bus. It sits directly upstream of the tri-state adder instances, one per requester, and drives their `enable` inputs. It grants the bus round-robin, guarantees that at most one driver is enabled in any cycle, and inserts a fixed all-off turnaround gap whenever bus ownership changes, so drivers never overlap on the net.

## Interface
- `M`, default 4: number of tri-state drivers/requesters; legal range 2..16.
- `HOLD`, default 4: maximum consecutive granted cycles for one owner while any other requester is pending; legal range ≥1.
- `TURN`, default 1: number of all-off cycles between two owners; legal range 1..7.
- `clk` input, 1 bit: single clock, rising edge.
- `rstN` input, 1 bit: reset, asynchronous, active-low.
- `req` input, M bits: bus request per driver, level-sensitive, sampled on `clk`.
- `enable` output, M bits: per-driver output enable, registered, zero-or-one-hot.
- `grant_id` output, $clog2(M) bits: index of the current owner; holds the last owner when idle.
- `bus_valid` output, 1 bit: high in any cycle where one `enable` bit is high (OR of `enable`, registered).

## Operation
- Reset (async, `rstN` low): `enable`=0, `bus_valid`=0, `grant_id`=0, state=IDLE, priority pointer=0, hold counter=0. Outputs clear immediately, without waiting for a clock edge.
- State machine: IDLE, GRANT, GAP.
- IDLE: if `req`≠0, pick the first set bit searching upward from the pointer with wrap. Go to GRANT, set `enable[k]`=1, set `grant_id`=k, set counter=1. Otherwise stay in IDLE.
- GRANT with owner k, evaluated at each edge:
  - `req[k]`=0: release.
  - `req[k]`=1, counter==HOLD, and some other `req` bit set: release.
  - Otherwise stay in GRANT and increment the counter, saturating at HOLD.
  - A lone requester holds the bus indefinitely.
- Release: `enable`=0, `bus_valid`=0, pointer=(k+1) mod M, go to GAP with gap counter=1. `grant_id` is unchanged.
- GAP: `enable` stays 0 for exactly TURN cycles. On the edge that ends the last GAP cycle, arbitrate as in IDLE using `req` sampled at that edge.
  - Winner found: enter GRANT directly.
  - `req`=0: enter IDLE.
- Invariants:
  - `$countones(enable)` ≤ 1 at all times.
  - `enable` is never nonzero in two consecutive cycles with different owners.
  - Only one owner changes per arbitration.
- A requester that drops and reasserts `req` during GAP or IDLE is treated as a new request, with no memory kept.
- Simultaneous release and a new request from the same k: the release wins, and k is lowest priority at the next arbitration.

## Timing
- All outputs are registered; there is no combinational path from `req` to `enable`.
- IDLE→GRANT latency: `req` high before edge n gives `enable` high in the cycle after edge n (1 cycle).
- Release latency: `req[k]` low before edge n gives `enable[k]` low after edge n.
- Handover gap: exactly TURN cycles of `enable`=0 between the last cycle of the old owner and the first cycle of the new owner.
- Under full contention each owner gets HOLD cycles, giving a period of M·(HOLD+TURN) cycles.
- `rstN` deassertion is synchronised externally; the first arbitration occurs on the first edge after release.

## Test plan
- Reset mid-grant, M=4: owner 2 granted, `rstN` pulled low between edges → `enable`=0000, `bus_valid`=0, `grant_id`=0 immediately. After release with `req`=0001 → `enable`=0001 one cycle later.
- Lone requester, `req`=0100 for 12 cycles → `enable`=0100 from cycle 2 through 12 with no gaps (HOLD not enforced). `req` drops → `enable`=0000 next cycle, and IDLE is reached after TURN.
- Full contention, `req`=1111 with HOLD=4 and TURN=1 → owners 0,1,2,3,0 in order, each exactly 4 cycles, exactly 1 all-zero cycle between them, period 20.
- Early release: owner 0 with `req`=0101, `req[0]` dropped after 2 granted cycles → 1 cycle of 0000, then `enable`=0100, `grant_id`=2.
- Pointer wrap: owner 3 released while `req`=1001 → next owner 0, then 3 only after 0 releases.
- Late request: `req` goes 0000→0010 during the last GAP cycle with TURN=3 → granted at the end of GAP with no extra IDLE cycle. A one-hot and overlap assertion stays active throughout all tests.
